// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: state encoding,
// requester identifiers and the default starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_IF = 2'd1,
        ST_GNT_DM = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported backing memory between instruction fetch and the
// data memory stage, one transaction at a time, with data priority and a fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    output logic          if_busy,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          dm_busy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_t    state_r,     state_s;
    logic          mem_req_r,   mem_req_s;
    logic          mem_we_r,    mem_we_s;
    logic [AW-1:0] mem_addr_r,  mem_addr_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_s;
    logic          if_ack_r,    if_ack_s;
    logic          dm_ack_r,    dm_ack_s;
    logic [DW-1:0] if_rdata_r,  if_rdata_s;
    logic [DW-1:0] dm_rdata_r,  dm_rdata_s;
    logic [CW-1:0] starve_r,    starve_s;
    logic          owner_s;
    logic          if_forced_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        sat_inc = (v == STARVE_LIM) ? v : v + CW'(1);
    endfunction

    assign owner_s     = (state_r == ST_GNT_DM) ? OWN_DM : OWN_IF;
    assign if_forced_s = if_req && (starve_r == STARVE_LIM);

    // Next-state, capture and response logic
    always_comb begin
        state_s     = state_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_ack_s    = 1'b0;
        dm_ack_s    = 1'b0;
        if_rdata_s  = if_rdata_r;
        dm_rdata_s  = dm_rdata_r;
        starve_s    = starve_r;
        case (state_r)
            ST_IDLE: begin
                if (dm_req && !if_forced_s) begin
                    state_s     = ST_GNT_DM;
                    mem_req_s   = 1'b1;
                    mem_we_s    = dm_we;
                    mem_addr_s  = dm_addr;
                    mem_wdata_s = dm_wdata;
                    starve_s    = if_req ? sat_inc(starve_r) : {CW{1'b0}};
                end else if (if_req) begin
                    state_s     = ST_GNT_IF;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = if_addr;
                    mem_wdata_s = {DW{1'b0}};
                    starve_s    = {CW{1'b0}};
                end else begin
                    starve_s    = {CW{1'b0}};
                end
            end
            ST_GNT_IF, ST_GNT_DM: begin
                if (mem_ack) begin
                    mem_req_s = 1'b0;
                    state_s   = ST_RESP;
                    if (owner_s == OWN_IF) begin
                        if_ack_s   = 1'b1;
                        if_rdata_s = mem_rdata;
                    end else if (!mem_we_r) begin
                        dm_ack_s   = 1'b1;
                        dm_rdata_s = mem_rdata;
                    end else begin
                        dm_ack_s   = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            // Requester updates its request at the end of the ack cycle; nothing is granted here
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            if_rdata_r  <= {DW{1'b0}};
            dm_rdata_r  <= {DW{1'b0}};
            starve_r    <= {CW{1'b0}};
        end else begin
            state_r     <= state_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_ack_r    <= if_ack_s;
            dm_ack_r    <= dm_ack_s;
            if_rdata_r  <= if_rdata_s;
            dm_rdata_r  <= dm_rdata_s;
            starve_r    <= starve_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_ack    = if_ack_r;
    assign dm_ack    = dm_ack_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_busy   = if_req & ~if_ack_r;
    assign dm_busy   = dm_req & ~dm_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, if_busy, dm_ack, dm_busy, mem_req, mem_we;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_busy(if_busy),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_busy(dm_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic        dmr;
        logic        dwe;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
        int          dly;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_ifack;
        logic        e_dmack;
        logic [31:0] e_ifrd;
        logic [31:0] e_dmrd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
    endtask

    // Wait for the next backing request, ack it one cycle later, report its address.
    task automatic serve(output logic [31:0] addr);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!mem_req) begin
            errors++;
            $display("FAIL serve_timeout: got mem_req=0 expected 1 within 20 cycles");
        end
        addr = mem_addr;
        step();
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        step();
        mem_ack = 1'b0;
    endtask

    // Randomized-run model state
    logic [31:0] mem_arr [64];
    logic        free_m, outst_m, own_dm_m, own_we_m, if_got, dm_got, ack_evt, exp_ifa, exp_dma;
    logic [31:0] own_addr_m, own_wd_m, exp_ifrd_m, exp_dmrd_m;
    int          consec_m, cnt_m;
    logic [31:0] got_addr;
    logic [31:0] exp_order [6];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,  32'h0,        32'hDEADBEEF, 2,
                    1'b0, 32'h100, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h80, 32'h0,        32'h0BADF00D, 1,
                    1'b0, 32'h80,  1'b0, 1'b1, 32'hDEADBEEF, 32'h0BADF00D};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h44, 32'h12345678, 32'hFFFFFFFF, 3,
                    1'b1, 32'h44,  1'b0, 1'b1, 32'hDEADBEEF, 32'h0BADF00D};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h48, 32'h0,        32'h11112222, 1,
                    1'b0, 32'h48,  1'b0, 1'b1, 32'hDEADBEEF, 32'h11112222};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h108, 32'h0,  32'h0,        32'hCAFEF00D, 1,
                    1'b0, 32'h108, 1'b1, 1'b0, 32'hCAFEF00D, 32'h11112222};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h0,  32'hA5A5A5A5, 32'h0,        2,
                    1'b1, 32'h0,   1'b0, 1'b1, 32'hCAFEF00D, 32'h11112222};

        do_reset();
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chkb("rst_if_ack", if_ack, 1'b0);
        chkb("rst_dm_ack", dm_ack, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chkb("rst_if_busy", if_busy, 1'b0);
        rst = 1'b0;

        // Single transactions from the vector table
        for (int v = 0; v < 6; v++) begin
            if_req = vecs[v].ifr; if_addr = vecs[v].ia;
            dm_req = vecs[v].dmr; dm_we = vecs[v].dwe; dm_addr = vecs[v].da; dm_wdata = vecs[v].dwd;
            step();
            chkb("vec_mem_req", mem_req, 1'b1);
            chkb("vec_mem_we", mem_we, vecs[v].e_we);
            chk("vec_mem_addr", mem_addr, vecs[v].e_addr);
            if (vecs[v].e_we) chk("vec_mem_wdata", mem_wdata, vecs[v].dwd);
            chkb("vec_if_busy", if_busy, vecs[v].ifr);
            chkb("vec_dm_busy", dm_busy, vecs[v].dmr);
            for (int d = 1; d < vecs[v].dly; d++) begin
                step();
                chkb("vec_hold_req", mem_req, 1'b1);
                chkb("vec_early_ack", if_ack | dm_ack, 1'b0);
            end
            mem_ack = 1'b1; mem_rdata = vecs[v].mrd;
            step();
            chkb("vec_if_ack", if_ack, vecs[v].e_ifack);
            chkb("vec_dm_ack", dm_ack, vecs[v].e_dmack);
            chk("vec_if_rdata", if_rdata, vecs[v].e_ifrd);
            chk("vec_dm_rdata", dm_rdata, vecs[v].e_dmrd);
            chkb("vec_req_drop", mem_req, 1'b0);
            idle_inputs();
            step();
            chkb("vec_idle", mem_req, 1'b0);
        end

        // Simultaneous requests: data write first, fetch granted after the response cycle
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
        step();
        chkb("both_mem_we", mem_we, 1'b1);
        chk("both_mem_addr", mem_addr, 32'h40);
        chk("both_mem_wdata", mem_wdata, 32'h12345678);
        chkb("both_if_busy", if_busy, 1'b1);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        step();
        chkb("both_dm_ack", dm_ack, 1'b1);
        chkb("both_if_ack", if_ack, 1'b0);
        chkb("both_if_busy_ack", if_busy, 1'b1);
        chk("both_dm_rdata_kept", dm_rdata, 32'h11112222);
        dm_req = 1'b0; mem_ack = 1'b0;
        step();
        chkb("both_no_grant_resp", mem_req, 1'b0);
        step();
        chkb("both_if_grant", mem_req, 1'b1);
        chk("both_if_addr", mem_addr, 32'h200);
        chkb("both_if_we", mem_we, 1'b0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h31415926;
        step();
        chkb("both_if_ack2", if_ack, 1'b1);
        chk("both_if_rdata", if_rdata, 32'h31415926);
        idle_inputs();
        step();

        // Starvation guard: both held, four data grants then one fetch grant
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h204;
        exp_order = '{32'h204, 32'h204, 32'h204, 32'h204, 32'h300, 32'h204};
        for (int g = 0; g < 6; g++) begin
            serve(got_addr);
            chk("starve_order", got_addr, exp_order[g]);
        end
        idle_inputs();
        step();
        step();
        step();

        // Reset while a data transaction is pending
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60;
        step();
        chkb("abort_granted", mem_req, 1'b1);
        rst = 1'b1;
        step();
        chkb("abort_req_low", mem_req, 1'b0);
        chkb("abort_no_ack", dm_ack, 1'b0);
        rst = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        step();
        chkb("abort_late_ack", dm_ack, 1'b0);
        chkb("abort_stay_idle", mem_req, 1'b0);
        mem_ack = 1'b0;
        step();
        chkb("abort_no_ack2", dm_ack, 1'b0);
        chk("abort_rdata_clr", dm_rdata, 32'h0);

        // Spurious mem_ack while idle, then fetch withdraws mid-grant
        mem_ack = 1'b1; mem_rdata = 32'h99;
        step();
        chkb("spur_no_ack", if_ack | dm_ack, 1'b0);
        chkb("spur_no_req", mem_req, 1'b0);
        mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        step();
        chkb("drop_grant", mem_req, 1'b1);
        chk("drop_addr", mem_addr, 32'h10);
        if_req = 1'b0;
        step();
        chkb("drop_hold", mem_req, 1'b1);
        chkb("drop_busy", if_busy, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h5EED5EED;
        step();
        chkb("drop_ack", if_ack, 1'b1);
        chk("drop_rdata", if_rdata, 32'h5EED5EED);
        mem_ack = 1'b0;
        step();
        chkb("drop_single_pulse", if_ack, 1'b0);
        chkb("drop_no_regrant", mem_req, 1'b0);
        step();
        chkb("drop_still_idle", mem_req | if_ack, 1'b0);

        // Randomized traffic against the transaction-level model
        for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
        do_reset();
        rst = 1'b0;
        free_m = 1'b1; outst_m = 1'b0; consec_m = 0; cnt_m = 0;
        if_got = 1'b0; dm_got = 1'b0; exp_ifrd_m = 32'h0; exp_dmrd_m = 32'h0;
        own_dm_m = 1'b0; own_we_m = 1'b0; own_addr_m = 32'h0; own_wd_m = 32'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!if_req || if_got) begin
                if ($urandom_range(2, 0) == 0) begin
                    if_req = 1'b1; if_addr = 32'($urandom_range(63, 0)) << 2;
                end else begin
                    if_req = 1'b0;
                end
            end
            if (!dm_req || dm_got) begin
                if ($urandom_range(1, 0) == 0) begin
                    dm_req = 1'b1; dm_we = 1'($urandom_range(1, 0));
                    dm_addr = 32'($urandom_range(63, 0)) << 2; dm_wdata = $urandom;
                end else begin
                    dm_req = 1'b0;
                end
            end
            if (outst_m) begin
                if (cnt_m == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_we ? $urandom : mem_arr[mem_addr[7:2]];
                end else begin
                    mem_ack = 1'b0;
                    cnt_m--;
                end
            end else begin
                mem_ack = ($urandom_range(7, 0) == 0);
                mem_rdata = $urandom;
            end
            step();
            ack_evt = mem_ack && outst_m;
            exp_ifa = ack_evt && !own_dm_m;
            exp_dma = ack_evt && own_dm_m;
            if (ack_evt) begin
                if (!own_dm_m) exp_ifrd_m = mem_arr[own_addr_m[7:2]];
                else if (!own_we_m) exp_dmrd_m = mem_arr[own_addr_m[7:2]];
                else mem_arr[own_addr_m[7:2]] = own_wd_m;
                outst_m = 1'b0;
            end
            if (free_m) begin
                if (dm_req && !(if_req && consec_m == STARVE)) begin
                    own_dm_m = 1'b1; own_we_m = dm_we; own_addr_m = dm_addr; own_wd_m = dm_wdata;
                    consec_m = !if_req ? 0 : (consec_m < STARVE ? consec_m + 1 : consec_m);
                    outst_m = 1'b1;
                end else if (if_req) begin
                    own_dm_m = 1'b0; own_we_m = 1'b0; own_addr_m = if_addr;
                    consec_m = 0;
                    outst_m = 1'b1;
                end else begin
                    consec_m = 0;
                end
                if (outst_m) begin
                    cnt_m = $urandom_range(3, 1);
                    chkb("rnd_we", mem_we, own_we_m);
                    chk("rnd_addr", mem_addr, own_addr_m);
                    if (own_we_m) chk("rnd_wdata", mem_wdata, own_wd_m);
                end
            end
            chkb("rnd_mem_req", mem_req, outst_m);
            chkb("rnd_if_ack", if_ack, exp_ifa);
            chkb("rnd_dm_ack", dm_ack, exp_dma);
            chk("rnd_if_rdata", if_rdata, exp_ifrd_m);
            chk("rnd_dm_rdata", dm_rdata, exp_dmrd_m);
            chkb("rnd_if_busy", if_busy, if_req & ~exp_ifa);
            chkb("rnd_dm_busy", dm_busy, dm_req & ~exp_dma);
            free_m = !outst_m && !ack_evt;
            if_got = exp_ifa;
            dm_got = exp_dma;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
